// File: rtl/padc_dig_corr.sv
// Digital back end for a pipelined ADC built from 1.5-bit stages. It delay-aligns the raw
// stage codes, forms the overlapped-add result, and flags and counts illegal codes (value 3).
module padc_dig_corr #(
  parameter int N_STAGES  = 7,
  parameter int OUT_W     = N_STAGES + 1,
  parameter bit TWOS_COMP = 1'b0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           dig_raw [N_STAGES],
  output logic [OUT_W-1:0]     dout,
  output logic                 dout_valid,
  output logic                 code_err,
  output logic [N_STAGES-1:0]  err_stage,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int                FILL_W    = $clog2(N_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N_STAGES - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(N_STAGES);
  localparam logic [OUT_W-1:0]  TC_OFFSET = (OUT_W'(1) << N_STAGES) - OUT_W'(1);

  logic [1:0] aligned [N_STAGES];

  // Stage i is i cycles late relative to stage 0, so it needs N_STAGES-1-i delay registers.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_align
    localparam int DEPTH = N_STAGES - 1 - i;
    if (DEPTH == 0) begin : g_direct
      assign aligned[i] = dig_raw[i];
    end else begin : g_delay
      logic [1:0] sr_q [DEPTH];
      logic [1:0] sr_d [DEPTH];

      always_comb begin
        sr_d[0] = dig_raw[i];
        for (int j = 1; j < DEPTH; j++) sr_d[j] = sr_q[j-1];
      end

      // NOTE: these delay lines are small register arrays, not RAM, so each entry is reset
      // to keep a partially filled pipeline from presenting stale codes after reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < DEPTH; j++) sr_q[j] <= '0;
        end else begin
          for (int j = 0; j < DEPTH; j++) sr_q[j] <= sr_d[j];
        end
      end

      assign aligned[i] = sr_q[DEPTH-1];
    end
  end

  logic [OUT_W-1:0]     sum;
  logic [N_STAGES-1:0]  err_mask;
  logic                 sample_ok;

  logic [FILL_W-1:0]    fill_q,       fill_d;
  logic [OUT_W-1:0]     dout_q,       dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 code_err_q,   code_err_d;
  logic [N_STAGES-1:0]  err_stage_q,  err_stage_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;

  // Overlapped add; an illegal code 3 is clamped to 2 and its stage is recorded.
  always_comb begin
    sum      = '0;
    err_mask = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      err_mask[i] = (aligned[i] == 2'd3);
      sum = sum + (OUT_W'(err_mask[i] ? 2'd2 : aligned[i]) << (N_STAGES - 1 - i));
    end
  end

  always_comb begin
    sample_ok    = (fill_q >= FILL_LAST);
    fill_d       = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    dout_d       = TWOS_COMP ? (sum - TC_OFFSET) : sum;
    dout_valid_d = dout_valid_q | sample_ok;
    code_err_d   = sample_ok & (|err_mask);
    err_stage_d  = sample_ok ? err_mask : '0;
    err_cnt_d    = err_cnt_q;
    if (code_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      err_stage_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      fill_q       <= fill_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      code_err_q   <= code_err_d;
      err_stage_q  <= err_stage_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign code_err   = code_err_q;
  assign err_stage  = err_stage_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_padc_dig_corr.sv
// Directed bench for padc_dig_corr: one offset-binary and one two's-complement instance share
// the same stage codes; expected values are hand-computed constants.
module tb_padc_dig_corr;

  localparam int N = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dig_raw [N];

  logic [7:0] dout_ob,   dout_tc;
  logic       valid_ob,  valid_tc;
  logic       cerr_ob,   cerr_tc;
  logic [6:0] estg_ob,   estg_tc;
  logic [7:0] ecnt_ob,   ecnt_tc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  padc_dig_corr #(.N_STAGES(N), .OUT_W(N+1), .TWOS_COMP(1'b0), .ERR_CNT_W(8)) u_dut_ob (
    .clk(clk), .rst(rst), .dig_raw(dig_raw), .dout(dout_ob), .dout_valid(valid_ob),
    .code_err(cerr_ob), .err_stage(estg_ob), .err_cnt(ecnt_ob)
  );

  padc_dig_corr #(.N_STAGES(N), .OUT_W(N+1), .TWOS_COMP(1'b1), .ERR_CNT_W(8)) u_dut_tc (
    .clk(clk), .rst(rst), .dig_raw(dig_raw), .dout(dout_tc), .dout_valid(valid_tc),
    .code_err(cerr_tc), .err_stage(estg_tc), .err_cnt(ecnt_tc)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance one clock edge; sample and drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive_all(input logic [1:0] v);
    for (int i = 0; i < N; i++) dig_raw[i] = v;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dout"},     dout_ob,  0);
    check({tag, "_dout_tc"},  dout_tc,  0);
    check({tag, "_valid"},    valid_ob, 0);
    check({tag, "_code_err"}, cerr_ob,  0);
    check({tag, "_err_stg"},  estg_ob,  0);
    check({tag, "_err_cnt"},  ecnt_ob,  0);
  endtask

  // Release reset with all stages at code v, verify the 7-edge fill, and land on valid.
  task automatic fill_from_release(input string tag, input logic [1:0] v,
                                   input logic [7:0] exp_ob, input logic [7:0] exp_tc);
    rst = 1'b0;
    drive_all(v);
    for (int e = 1; e < N; e++) begin
      tick();
      check({tag, "_fill_valid"}, valid_ob, 0);
      check({tag, "_fill_code_err"}, cerr_ob, 0);
    end
    tick();
    check({tag, "_valid"},    valid_ob, 1);
    check({tag, "_valid_tc"}, valid_tc, 1);
    check({tag, "_dout"},     dout_ob,  exp_ob);
    check({tag, "_dout_tc"},  dout_tc,  exp_tc);
    check({tag, "_code_err"}, cerr_ob,  0);
    check({tag, "_err_cnt"},  ecnt_ob,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_all(2'd0);
    ticks(2);
    check_cleared("reset");

    // All stages at code 1: 127 offset-binary, 0 two's-complement.
    fill_from_release("ones", 2'd1, 8'd127, 8'd0);
    ticks(3);
    check("ones_hold", dout_ob, 127);

    // 1 -> 2 step: sample just before the step has stage 0 still at 1 (64 + 126 = 190).
    drive_all(2'd2);
    ticks(6);
    check("step2_prev",    dout_ob, 190);
    check("step2_prev_tc", dout_tc, 63);
    tick();
    check("step2",    dout_ob, 254);
    check("step2_tc", dout_tc, 127);

    // 2 -> 0 step: previous sample keeps only stage 0 at 2 (128).
    drive_all(2'd0);
    ticks(6);
    check("step0_prev",    dout_ob, 128);
    check("step0_prev_tc", dout_tc, 1);
    tick();
    check("step0",    dout_ob, 0);
    check("step0_tc", dout_tc, 8'h81);
    check("step0_valid", valid_ob, 1);

    // Single staggered sample: only stage 0 carries code 2, for one cycle.
    dig_raw[0] = 2'd2;
    tick();
    dig_raw[0] = 2'd0;
    ticks(5);
    check("stag_before", dout_ob, 0);
    tick();
    check("stag_hit",      dout_ob, 128);
    check("stag_hit_tc",   dout_tc, 1);
    check("stag_code_err", cerr_ob, 0);
    tick();
    check("stag_after", dout_ob, 0);

    // Illegal code 3 on stage 3 for one sample, others at 1: 127 + 8 = 135.
    drive_all(2'd1);
    ticks(8);
    check("ill_base", dout_ob, 127);
    dig_raw[3] = 2'd3;
    tick();
    dig_raw[3] = 2'd1;
    ticks(2);
    check("ill_before_err",  cerr_ob, 0);
    check("ill_before_dout", dout_ob, 127);
    tick();
    check("ill_dout",     dout_ob, 135);
    check("ill_dout_tc",  dout_tc, 8);
    check("ill_code_err", cerr_ob, 1);
    check("ill_err_stg",  estg_ob, 7'b0001000);
    check("ill_err_cnt",  ecnt_ob, 1);
    check("ill_err_tc",   cerr_tc, 1);
    tick();
    check("ill_after_err", cerr_ob, 0);
    check("ill_after_stg", estg_ob, 0);
    check("ill_after_cnt", ecnt_ob, 1);
    check("ill_after_dout", dout_ob, 127);

    // Stage 6 (no delay) illegal for 300 consecutive samples; counter starts at 1.
    dig_raw[6] = 2'd3;
    ticks(100);
    check("sat_cnt_101", ecnt_ob, 101);
    check("sat_code_err", cerr_ob, 1);
    check("sat_err_stg",  estg_ob, 7'b1000000);
    check("sat_dout",     dout_ob, 128);
    ticks(154);
    check("sat_cnt_255", ecnt_ob, 255);
    ticks(46);
    check("sat_cnt_hold", ecnt_ob, 255);
    dig_raw[6] = 2'd1;
    tick();
    check("sat_end_err", cerr_ob, 0);
    check("sat_end_cnt", ecnt_ob, 255);

    // Reset mid-stream: clears asynchronously, then refills over 7 edges.
    drive_all(2'd2);
    ticks(8);
    check("mid_pre_dout", dout_ob, 254);
    rst = 1'b1;
    #2;
    check_cleared("mid_rst");
    check("mid_rst_valid_tc", valid_tc, 0);
    tick();
    fill_from_release("mid_refill", 2'd2, 8'd254, 8'd127);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
